btn_debounce_sync: RTL
======================

// Module: btn_debounce_sync
// PURPOSE
//   Conditions raw active-low pushbuttons for the ALU operand selector. Provides 2-flop sync, per-bit debounce FSM
//   and press/release pulses. btn_stable is the 4-bit pattern the selector decodes into operands a/b; idle 4'b1111.
// PARAMETERS
//   WIDTH            4       number of buttons
//   SYNC_STAGES      2       synchronizer flops per bit (>=2)
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles needed to accept a level (10 ms @ 50 MHz); sim uses 4
//   CNT_W            19      counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   btn_raw      in   WIDTH  raw button pins, active-low, asynchronous to clk
//   btn_stable   out  WIDTH  debounced level, active-low (feeds operand selector B)
//   btn_press    out  WIDTH  1-cycle pulse per bit on accepted 1->0 of btn_stable
//   btn_release  out  WIDTH  1-cycle pulse per bit on accepted 0->1 of btn_stable
//   any_change   out  1      OR of btn_press|btn_release, same cycle
// BEHAVIOUR
//   Reset (async assert, sync deassert by design): sync flops=1, btn_stable=all 1s, pulses=0, counters=0, FSM=REL.
//   Sync: btn_raw -> SYNC_STAGES flops; s = last stage. No logic on unsynced signal.
//   Per-bit FSM, 4 states, independent per bit:
//     REL   (stable=1): s==0 -> CHK_P, cnt<=1; else stay, cnt<=0.
//     CHK_P (stable=1): s==1 -> REL, cnt<=0 (bounce discarded, no pulse);
//                       s==0 && cnt==DEBOUNCE_CYCLES-1 -> PRS, stable<=0, press pulse, cnt<=0;
//                       else cnt<=cnt+1.
//     PRS   (stable=0): s==1 -> CHK_R, cnt<=1; else stay.
//     CHK_R (stable=0): s==0 -> PRS, cnt<=0; s==1 && cnt==DEBOUNCE_CYCLES-1 -> REL, stable<=1, release pulse,
//                       cnt<=0; else cnt<=cnt+1.
//   Timing: s must hold new level DEBOUNCE_CYCLES consecutive cycles; btn_stable changes on the edge
//     SYNC_STAGES+DEBOUNCE_CYCLES after first clock edge sampling the new raw level. Pulse asserted in the same
//     cycle btn_stable changes, exactly one cycle wide, registered (no comb path from btn_raw).
//   Any single-cycle opposite sample in CHK_* restarts qualification from zero; no partial credit.
//   Simultaneous presses on several bits: each bit qualifies independently; pulses may coincide.
//   Counter saturates by construction (never exceeds DEBOUNCE_CYCLES-1); no wrap.
//   Reset mid-qualification: counter discarded, btn_stable returns to 1s, no pulse on or after reset release
//     unless raw low then requalifies for full DEBOUNCE_CYCLES.
//   DEBOUNCE_CYCLES==1: accept on first cycle s differs (CHK state transited with cnt==0 check via REL path).
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//   1 reset asserted mid-run -> btn_stable=4'b1111, pulses 0 immediately (async), no pulse after release.
//   2 btn_raw=4'b1110 held -> btn_stable=4'b1110 exactly 6 edges later, btn_press=4'b0001 for 1 cycle.
//   3 btn_raw[0] low 3 cycles then high 1, repeat -> btn_stable stays 4'b1111, no pulses.
//   4 from 4'b1110 return raw to 4'b1111 held -> btn_stable=4'b1111 after 6 edges, btn_release=4'b0001, any_change=1.
//   5 btn_raw 1111->1100 same edge -> btn_stable=4'b1100 same cycle, btn_press=4'b0011 in one cycle.
//   6 bit1 pressed, 2 cycles later bit3 pressed -> two separate single-cycle pulses 2 cycles apart; final 4'b0101.

Source files
------------

// File: rtl/btn_debounce_sync.sv
// Synchronises and debounces active-low buttons, emitting registered press/release pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from raw change to btn_stable; no backpressure, outputs always valid.
module btn_debounce_sync #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_stable,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             any_change
);

    typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             stb_q, stb_d;
        logic             prs_q, prs_d;
        logic             rls_q, rls_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            stb_d   = stb_q;
            prs_d   = 1'b0;
            rls_d   = 1'b0;
            case (state_q)
                REL: begin
                    if (!s[g]) begin
                        // A one-cycle qualification window skips the check state entirely
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = PRS;
                            stb_d   = 1'b0;
                            prs_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = CHK_P;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                CHK_P: begin
                    if (s[g]) begin
                        state_d = REL;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRS;
                        stb_d   = 1'b0;
                        prs_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRS: begin
                    if (s[g]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = REL;
                            stb_d   = 1'b1;
                            rls_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = CHK_R;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CHK_R: begin
                    if (!s[g]) begin
                        state_d = PRS;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = REL;
                        stb_d   = 1'b1;
                        rls_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = REL;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= REL;
                cnt_q   <= '0;
                stb_q   <= 1'b1;
                prs_q   <= 1'b0;
                rls_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                stb_q   <= stb_d;
                prs_q   <= prs_d;
                rls_q   <= rls_d;
            end
        end

        assign btn_stable[g]  = stb_q;
        assign btn_press[g]   = prs_q;
        assign btn_release[g] = rls_q;
    end

    assign any_change = |(btn_press | btn_release);

endmodule
